dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (SPI slave FSM) and port 1 (local host/test).

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb_rr.sv | 30 +++
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_P0 = 1'b0;
  localparam owner_t OWNER_P1 = 1'b1;

  // The wait counter only ever holds READ_LAT-1 down to 0.
  function automatic int wait_cnt_w(input int lat);
    return (lat < 3) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - two-way round-robin picker holding the priority pointer
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  owner_t r_ptr;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = (r_ptr == OWNER_P1) ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other port gets priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= OWNER_P0;
    end else if (i_advance && (o_grant != 2'b00)) begin
      r_ptr <= o_grant[0] ? OWNER_P1 : OWNER_P0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory between two requesters
// Optional feature: DMEM_ARB_LOCK_EN adds req0_lock for port-0 read-modify-write sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              req0_lock,
`endif
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W     = wait_cnt_w(READ_LAT);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(READ_LAT - 1);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_we;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;

  logic              w_lock_held;
  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_accept;
  owner_t            w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifdef DMEM_ARB_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= 1'b0;
    end else if (w_accept && (w_win == OWNER_P0)) begin
      r_lock <= req0_lock;
    end
  end

  assign w_lock_held = r_lock;
`else
  assign w_lock_held = 1'b0;
`endif

  assign w_valid  = {req1_valid & ~w_lock_held, req0_valid};
  assign w_accept = ~reset && (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_win    = w_grant[1] ? OWNER_P1 : OWNER_P0;
  assign w_we     = w_grant[1] ? req1_we    : req0_we;
  assign w_addr   = w_grant[1] ? req1_addr  : req0_addr;
  assign w_wdata  = w_grant[1] ? req1_wdata : req0_wdata;

  dmem_arb_rr u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (w_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  assign req0_ready = w_accept & w_grant[0];
  assign req1_ready = w_accept & w_grant[1];

  // Registered outputs are masked while reset is high so an aborted access never reaches memory.
  assign mem_en     = r_mem_en & ~reset;
  assign mem_we     = r_mem_we & ~reset;
  assign mem_addr   = reset ? '0 : r_mem_addr;
  assign mem_wdata  = reset ? '0 : r_mem_wdata;
  assign rsp0_valid = r_rsp0_valid & ~reset;
  assign rsp1_valid = r_rsp1_valid & ~reset;
  assign rsp0_rdata = reset ? '0 : r_rsp0_rdata;
  assign rsp1_rdata = reset ? '0 : r_rsp1_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_P0;
      r_we         <= 1'b0;
      r_wait_cnt   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner     <= w_win;
            r_we        <= w_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            if (r_owner == OWNER_P1) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_rdata <= '0;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_rdata <= '0;
            end
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= WAIT_INIT;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            if (r_owner == OWNER_P1) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_rdata <= mem_rdata;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_rdata <= mem_rdata;
            end
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (lock sequence built with DMEM_ARB_LOCK_EN)
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
`ifdef DMEM_ARB_LOCK_EN
  logic       req0_lock;
`endif
  logic       req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic       mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic       mem_clear;
  logic [7:0] bmem [128];

  typedef struct packed {
    logic       port;
    logic [7:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(8), .READ_LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DMEM_ARB_LOCK_EN
    .req0_lock  (req0_lock),
`endif
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: content i^0x3C until written, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) bmem[i] <= 8'(i) ^ 8'h3C;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= bmem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      check("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_port", {31'b0, rsp1_valid}, {31'b0, mon_e.port});
        check("rsp_rdata", {24'b0, rsp1_valid ? rsp1_rdata : rsp0_rdata}, {24'b0, mon_e.rdata});
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, mem_we, 26'b0} |
           {11'b0, mem_addr, mem_wdata, 6'b0} | {16'b0, rsp0_rdata, rsp1_rdata};
  endfunction

  // Waits for a grant, records the expected response for the winner; waited = cycles before grant.
  task automatic wait_grant(input logic [7:0] exp0, input logic [7:0] exp1,
                            output int port, output int waited);
    port   = -1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
        port = req0_ready ? 0 : 1;
        exp_q.push_back('{port: req1_ready, rdata: req0_ready ? exp0 : exp1});
        break;
      end
      waited++;
    end
    if (port < 0) check("grant_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int port, waited;
  int seq [4];

  initial begin
    mem_clear  = 1'b1;
    reset      = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    req0_lock  = 1'b0;
`endif
    @(posedge clk); #1;
    mem_clear = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(1);

    // Test 1: reset for two cycles while a port-0 read is in ACCESS.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'h05;
    @(negedge clk);
    check("t1_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t1_reset_c1_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_reset_c2_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h05;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'h11;
    wait_grant(8'h39, 8'h2D, port, waited);
    check("t1_ptr0_winner", port, 32'd0);
    check("t1_idle_after_reset", waited, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(5);

    // Test 2: port-0 write 0x05 <= 0xA5.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 7'h05; req0_wdata = 8'hA5;
    @(negedge clk);
    check("t2_ready0_at_T", {31'b0, req0_ready}, 32'd1);
    if (req0_ready) exp_q.push_back('{port: 1'b0, rdata: 8'h00});
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_we = 1'b0;
    @(negedge clk);
    check("t2_mem_T1", {16'b0, mem_en, mem_we, mem_addr, 7'b0}, {16'b0, 1'b1, 1'b1, 7'h05, 7'b0});
    check("t2_wdata_T1", {24'b0, mem_wdata}, 32'hA5);
    @(negedge clk);
    check("t2_rsp0_T2", {30'b0, rsp0_valid, rsp1_valid}, 32'b10);
    @(negedge clk);
    check("t2_mem_idle", {30'b0, mem_en, mem_we}, 32'd0);
    idle_cycles(2);

    // Test 3: port-1 read back 0x05.
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'h05;
    @(negedge clk);
    check("t3_ready1_at_T", {31'b0, req1_ready}, 32'd1);
    if (req1_ready) exp_q.push_back('{port: 1'b1, rdata: 8'hA5});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("t3_mem_T1", {16'b0, mem_en, mem_we, mem_addr, 7'b0}, {16'b0, 1'b1, 1'b0, 7'h05, 7'b0});
    @(negedge clk);
    check("t3_no_rsp_T2", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    @(negedge clk);
    check("t3_rsp1_T3", {30'b0, rsp0_valid, rsp1_valid}, 32'b01);
    check("t3_rdata_T3", {24'b0, rsp1_rdata}, 32'hA5);
    idle_cycles(2);

    // Test 4: both ports read continuously; pointer starts at port 0.
    seq = '{0, 1, 0, 1};
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'h05;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'h11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(8'hA5, 8'h2D, port, waited);
      check($sformatf("t4_grant%0d", k), port, seq[k]);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(5);

    // Test 5: reset during the WAIT cycle of a port-0 read.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'h05;
    @(negedge clk);
    check("t5_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_in_wait", {29'b0, mem_we, rsp0_valid, rsp1_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 7'h30; req1_wdata = 8'h5A;
    @(negedge clk);
    check("t5_idle_after_reset", {31'b0, req1_ready}, 32'd1);
    if (req1_ready) exp_q.push_back('{port: 1'b1, rdata: 8'h00});
    @(posedge clk); #1;
    req1_valid = 1'b0; req1_we = 1'b0;
    idle_cycles(5);

`ifdef DMEM_ARB_LOCK_EN
    // Lock: port 0 keeps the memory until it is accepted with lock=0.
    seq = '{0, 0, 0, 1};
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'h05; req0_lock = 1'b1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'h11;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req0_lock = 1'b0;
      wait_grant(8'hA5, 8'h2D, port, waited);
      check($sformatf("lock_grant%0d", k), port, seq[k]);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(5);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
